// File: rtl/fetch_seq_ctrl.sv
// Fetch sequencer: runs one instruction-memory request at a time. It merges memory wait
// states with hazard stalls and EX redirects, and drops responses that a redirect made stale.
module fetch_seq_ctrl #(
    parameter int P_DATA_WIDTH = 32,
    parameter int PC_WIDTH     = 9,
    parameter int P_CNT_WIDTH  = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [PC_WIDTH:0]       i_pc_f,
    input  logic                    i_hazard_stall,
    input  logic                    i_pcsrc_e,
    output logic                    o_mem_req,
    output logic [PC_WIDTH:0]       o_mem_addr,
    input  logic                    i_mem_gnt,
    input  logic                    i_mem_rvalid,
    input  logic [P_DATA_WIDTH-1:0] i_mem_rdata,
    output logic [P_DATA_WIDTH-1:0] o_instr_f,
    output logic                    o_instr_valid,
    output logic                    o_stall_f,
    output logic                    o_stall_d,
    output logic                    o_flush_d,
    output logic [P_CNT_WIDTH-1:0]  o_stall_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DROP
    } state_t;

    state_t                  state_q, state_d;
    logic [P_DATA_WIDTH-1:0] hold_buf_q;
    logic                    hold_cap;
    logic [P_CNT_WIDTH-1:0]  cnt_q;
    logic                    is_idle;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        hold_cap      = 1'b0;
        o_mem_req     = 1'b0;
        o_instr_f     = '0;
        o_instr_valid = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                o_mem_req = 1'b1;
                if (i_mem_gnt) state_d = i_pcsrc_e ? S_DROP : S_WAIT;
            end
            S_WAIT: begin
                o_instr_f     = i_mem_rdata;
                o_instr_valid = i_mem_rvalid & ~i_pcsrc_e;
                if (i_mem_rvalid) begin
                    if (i_pcsrc_e) begin
                        state_d = S_REQ;
                    end else if (i_hazard_stall) begin
                        // Decode cannot take it yet; park it until the hazard clears.
                        hold_cap = 1'b1;
                        state_d  = S_HOLD;
                    end else begin
                        state_d = S_REQ;
                    end
                end else if (i_pcsrc_e) begin
                    state_d = S_DROP;
                end
            end
            S_HOLD: begin
                o_instr_f     = hold_buf_q;
                o_instr_valid = ~i_pcsrc_e;
                if (i_pcsrc_e || !i_hazard_stall) state_d = S_REQ;
            end
            S_DROP: begin
                // The memory still owes one response for the old path; it is absorbed here.
                if (i_mem_rvalid) state_d = S_REQ;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign o_mem_addr = o_mem_req ? i_pc_f : '0;
    assign is_idle    = (state_q == S_IDLE);

    // IDLE has a fixed output set: PC frozen, decode fed a bubble.
    always_comb begin
        if (is_idle) begin
            o_stall_f = 1'b1;
            o_stall_d = 1'b0;
            o_flush_d = 1'b1;
        end else begin
            o_stall_f = ~i_pcsrc_e & (i_hazard_stall | ~o_instr_valid);
            o_stall_d = i_hazard_stall & ~i_pcsrc_e;
            o_flush_d = i_pcsrc_e | (~o_instr_valid & ~i_hazard_stall);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hold_buf_q <= '0;
        end else if (hold_cap) begin
            hold_buf_q <= i_mem_rdata;
        end
    end

    // Counts only the stall cycles caused by memory, not those caused by hazards. Saturates.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else if (o_stall_f && !i_hazard_stall && !(&cnt_q)) begin
            cnt_q <= cnt_q + {{(P_CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign o_stall_cnt = cnt_q;

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// Bench for fetch_seq_ctrl. It applies a directed vector table, a counter saturation run, and
// random traffic checked against a transaction-level reference model.
module tb_fetch_seq_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic [9:0]  i_pc_f;
    logic        i_hazard_stall, i_pcsrc_e;
    logic        o_mem_req;
    logic [9:0]  o_mem_addr;
    logic        i_mem_gnt, i_mem_rvalid;
    logic [31:0] i_mem_rdata;
    logic [31:0] o_instr_f;
    logic        o_instr_valid, o_stall_f, o_stall_d, o_flush_d;
    logic [15:0] o_stall_cnt;

    int n_cmp = 0;
    int n_err = 0;

    fetch_seq_ctrl #(.P_DATA_WIDTH(32), .PC_WIDTH(9), .P_CNT_WIDTH(16)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_pc_f(i_pc_f),
        .i_hazard_stall(i_hazard_stall), .i_pcsrc_e(i_pcsrc_e),
        .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr),
        .i_mem_gnt(i_mem_gnt), .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata),
        .o_instr_f(o_instr_f), .o_instr_valid(o_instr_valid),
        .o_stall_f(o_stall_f), .o_stall_d(o_stall_d), .o_flush_d(o_flush_d),
        .o_stall_cnt(o_stall_cnt)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        rst_n;
        logic [9:0]  pc;
        logic        hz, pcs, gnt, rv;
        logic [31:0] rdata;
        logic        req;
        logic [9:0]  addr;
        logic        vld;
        logic [31:0] instr;
        logic        sf, sd, fd;
        logic [15:0] cnt;
    } vec_t;

    function automatic vec_t mk(logic r, logic [9:0] pc, logic hz, logic pcs, logic gnt, logic rv,
                                logic [31:0] rd, logic req, logic [9:0] addr, logic vld,
                                logic [31:0] ins, logic sf, logic sd, logic fd, logic [15:0] cnt);
        vec_t v;
        v.rst_n = r; v.pc = pc; v.hz = hz; v.pcs = pcs; v.gnt = gnt; v.rv = rv; v.rdata = rd;
        v.req = req; v.addr = addr; v.vld = vld; v.instr = ins;
        v.sf = sf; v.sd = sd; v.fd = fd; v.cnt = cnt;
        return v;
    endfunction

    // Address only has meaning while a request is driven.
    function automatic logic [63:0] pack(logic req, logic [9:0] addr, logic vld, logic [31:0] ins,
                                         logic sf, logic sd, logic fd, logic [15:0] cnt);
        return {1'b0, req, (req ? addr : 10'h0), vld, ins, sf, sd, fd, cnt};
    endfunction

    function automatic logic [63:0] dut_pack();
        return pack(o_mem_req, o_mem_addr, o_instr_valid, o_instr_f,
                    o_stall_f, o_stall_d, o_flush_d, o_stall_cnt);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h (req,addr,vld,instr,sf,sd,fd,cnt)", name, act, exp);
        end
    endtask

    task automatic drive(input logic [9:0] pc, input logic hz, input logic pcs, input logic gnt,
                         input logic rv, input logic [31:0] rd);
        i_pc_f = pc; i_hazard_stall = hz; i_pcsrc_e = pcs;
        i_mem_gnt = gnt; i_mem_rvalid = rv; i_mem_rdata = rd;
    endtask

    // Reference model: tracks the fetch as a transaction (first cycle after reset,
    // an outstanding response that is live or stale, an instruction parked for decode).
    bit          m_boot, m_out, m_stale, m_held;
    logic [31:0] m_hbuf;
    int          m_cnt;

    task automatic model_reset();
        m_boot = 1; m_out = 0; m_stale = 0; m_held = 0; m_hbuf = '0; m_cnt = 0;
    endtask

    function automatic logic [63:0] model_exp();
        logic req, vld, sf, sd, fd;
        logic [31:0] ins;
        req = 0; vld = 0; ins = '0;
        if (m_boot) begin
            sf = 1; sd = 0; fd = 1;
        end else begin
            if (m_held) begin
                vld = ~i_pcsrc_e; ins = m_hbuf;
            end else if (!m_out) begin
                req = 1;
            end else if (!m_stale) begin
                ins = i_mem_rdata; vld = i_mem_rvalid & ~i_pcsrc_e;
            end
            sf = ~i_pcsrc_e & (i_hazard_stall | ~vld);
            sd = i_hazard_stall & ~i_pcsrc_e;
            fd = i_pcsrc_e | (~vld & ~i_hazard_stall);
        end
        return pack(req, i_pc_f, vld, ins, sf, sd, fd, m_cnt[15:0]);
    endfunction

    task automatic model_step(input logic [63:0] e);
        logic sf;
        sf = e[18];
        if (sf && !i_hazard_stall && m_cnt < 65535) m_cnt++;
        if (m_boot) m_boot = 0;
        else if (m_held) begin
            if (i_pcsrc_e || !i_hazard_stall) m_held = 0;
        end else if (!m_out) begin
            if (i_mem_gnt) begin m_out = 1; m_stale = i_pcsrc_e; end
        end else if (m_stale) begin
            if (i_mem_rvalid) begin m_out = 0; m_stale = 0; end
        end else if (i_mem_rvalid) begin
            m_out = 0;
            if (!i_pcsrc_e && i_hazard_stall) begin m_held = 1; m_hbuf = i_mem_rdata; end
        end else if (i_pcsrc_e) begin
            m_stale = 1;
        end
    endtask

    vec_t vt[$];

    initial begin
        logic [63:0] e;
        // rst pc  hz pcs gnt rv rdata          | req addr vld instr       sf sd fd cnt
        vt.push_back(mk(1, 10'h000, 0,0,0,0, 32'h0,        0,10'h000,0,32'h0,        1,0,1, 0));
        vt.push_back(mk(1, 10'h000, 0,0,1,0, 32'h0,        1,10'h000,0,32'h0,        1,0,1, 1));
        vt.push_back(mk(1, 10'h004, 0,0,0,1, 32'h00500093, 0,10'h000,1,32'h00500093, 0,0,0, 2));
        vt.push_back(mk(1, 10'h004, 0,0,1,0, 32'h0,        1,10'h004,0,32'h0,        1,0,1, 2));
        vt.push_back(mk(1, 10'h008, 0,0,0,0, 32'h0,        0,10'h000,0,32'h0,        1,0,1, 3));
        vt.push_back(mk(1, 10'h008, 0,0,0,0, 32'h0,        0,10'h000,0,32'h0,        1,0,1, 4));
        vt.push_back(mk(1, 10'h008, 1,0,0,1, 32'h00500093, 0,10'h000,1,32'h00500093, 1,1,0, 5));
        vt.push_back(mk(1, 10'h008, 1,0,0,0, 32'h0,        0,10'h000,1,32'h00500093, 1,1,0, 5));
        vt.push_back(mk(1, 10'h008, 0,0,0,0, 32'h0,        0,10'h000,1,32'h00500093, 0,0,0, 5));
        vt.push_back(mk(1, 10'h008, 0,0,1,0, 32'h0,        1,10'h008,0,32'h0,        1,0,1, 5));
        vt.push_back(mk(1, 10'h040, 0,1,0,0, 32'h0,        0,10'h000,0,32'h0,        0,0,1, 6));
        vt.push_back(mk(1, 10'h040, 0,0,0,0, 32'h0,        0,10'h000,0,32'h0,        1,0,1, 6));
        vt.push_back(mk(1, 10'h040, 0,0,0,1, 32'hDEADBEEF, 0,10'h000,0,32'h0,        1,0,1, 7));
        vt.push_back(mk(1, 10'h040, 0,1,1,0, 32'h0,        1,10'h040,0,32'h0,        0,0,1, 8));
        vt.push_back(mk(1, 10'h080, 0,0,0,1, 32'hDEADBEEF, 0,10'h000,0,32'h0,        1,0,1, 8));
        vt.push_back(mk(1, 10'h080, 0,0,0,0, 32'h0,        1,10'h080,0,32'h0,        1,0,1, 9));
        vt.push_back(mk(1, 10'h080, 0,0,1,0, 32'h0,        1,10'h080,0,32'h0,        1,0,1, 10));
        vt.push_back(mk(1, 10'h100, 0,1,0,1, 32'h12345678, 0,10'h000,0,32'h12345678, 0,0,1, 11));
        vt.push_back(mk(1, 10'h100, 1,0,0,0, 32'h0,        1,10'h100,0,32'h0,        1,1,0, 11));
        vt.push_back(mk(1, 10'h100, 0,0,1,0, 32'h0,        1,10'h100,0,32'h0,        1,0,1, 11));
        vt.push_back(mk(0, 10'h100, 0,0,0,0, 32'hAAAA5555, 0,10'h000,0,32'h0,        1,0,1, 0));
        vt.push_back(mk(1, 10'h200, 0,0,0,1, 32'hBBBB0000, 0,10'h000,0,32'h0,        1,0,1, 0));
        vt.push_back(mk(1, 10'h200, 0,0,0,1, 32'hBBBB0000, 1,10'h200,0,32'h0,        1,0,1, 1));
        vt.push_back(mk(1, 10'h200, 0,0,1,0, 32'h0,        1,10'h200,0,32'h0,        1,0,1, 2));
        vt.push_back(mk(1, 10'h200, 0,0,0,1, 32'hCAFEF00D, 0,10'h000,1,32'hCAFEF00D, 0,0,0, 3));

        i_rst_n = 1'b0;
        drive(10'h0, 0, 0, 0, 0, 32'h0);
        #1;
        chk("reset", dut_pack(), pack(0, 10'h0, 0, 32'h0, 1, 0, 1, 16'h0));
        repeat (2) @(posedge i_clk);

        for (int i = 0; i < vt.size(); i++) begin
            #1;
            i_rst_n = vt[i].rst_n;
            drive(vt[i].pc, vt[i].hz, vt[i].pcs, vt[i].gnt, vt[i].rv, vt[i].rdata);
            @(negedge i_clk);
            chk($sformatf("vec%0d", i), dut_pack(),
                pack(vt[i].req, vt[i].addr, vt[i].vld, vt[i].instr,
                     vt[i].sf, vt[i].sd, vt[i].fd, vt[i].cnt));
            @(posedge i_clk);
        end

        // Saturation: sit in REQ with no grant for 2^16+5 cycles.
        #1; i_rst_n = 1'b0; drive(10'h3FC, 0, 0, 0, 0, 32'h0);
        @(posedge i_clk); #1; i_rst_n = 1'b1;
        for (int k = 0; k <= 65541; k++) begin
            @(negedge i_clk);
            if (k == 65534)
                chk("cnt_near_sat", {48'h0, o_stall_cnt}, 64'hFFFE);
            if (k == 65541) begin
                chk("cnt_sat", {48'h0, o_stall_cnt}, 64'hFFFF);
                chk("sat_still_req", {63'h0, o_mem_req}, 64'h1);
            end
            @(posedge i_clk); #1;
        end

        // Random traffic against the model; responses only arrive while one is owed,
        // with occasional spurious rvalid where the controller must ignore it.
        i_rst_n = 1'b0; drive(10'h0, 0, 0, 0, 0, 32'h0);
        @(posedge i_clk); #1;
        i_rst_n = 1'b1; model_reset();
        for (int c = 0; c < 3000; c++) begin
            drive(10'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
                  1'($urandom_range(0, 1)),
                  m_out ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0),
                  $urandom);
            @(negedge i_clk);
            e = model_exp();
            chk($sformatf("rand%0d", c), dut_pack(), e);
            model_step(e);
            @(posedge i_clk); #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
